// File: rtl/divisor_pkg.sv
// Shared definitions for the signed divider: operand width, FSM encoding and
// the two's-complement helpers used by the datapath.
package divisor_pkg;

  localparam int N     = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Magnitude as an unsigned value, so the most negative number maps to itself.
  function automatic logic [N-1:0] abs_val(input logic [N-1:0] x);
    return x[N-1] ? -x : x;
  endfunction

  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

endpackage

// File: rtl/divisor_if.sv
// Request/result bundle between a requester (master) and the divider (slave).
interface divisor_if;
  import divisor_pkg::*;

  logic [N-1:0] outA;
  logic [N-1:0] outB;
  logic         divOrMult;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic         divZero;
  logic         divDone;

  modport master (
    output outA, outB, divOrMult,
    input  lo, hi, divZero, divDone
  );

  modport slave (
    input  outA, outB, divOrMult,
    output lo, hi, divZero, divDone
  );

endinterface

// File: rtl/divisor_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-2:0] quot_i,
  input  logic         dvd_bit_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);

  logic [W:0] rem_sh;
  logic [W:0] diff;

  assign rem_sh = {rem_i, dvd_bit_i};
  // rem_i < dvsr_i always holds, so the MSB of the 33-bit difference is a true sign.
  assign diff   = rem_sh - {1'b0, dvsr_i};
  assign rem_o  = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
  assign quot_o = {quot_i, ~diff[W]};

endmodule

// File: rtl/divisor.sv
// 32-bit signed divider: sign/magnitude split, 32 restoring steps, sign fixup.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module divisor #(
  parameter int N = 32
) (
  input  logic     clock,
  input  logic     reset,
  divisor_if.slave bus
);
  import divisor_pkg::*;

  state_e           state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvsr_q, dvsr_d;
  logic             sgn_a_q, sgn_a_d;
  logic             sgn_b_q, sgn_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     lo_q, lo_d;
  logic [N-1:0]     hi_q, hi_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             b_zero;
  logic             last_step;
  logic [N-1:0]     step_rem;
  logic [N-1:0]     step_quot;

  assign b_zero    = (bus.outB == '0);
  assign last_step = (cnt_q == CNT_W'(N - 1));

  // Dividend magnitude is shifted out MSB-first, one bit per step.
  div_step #(.W(N)) u_div_step (
    .rem_i     (acc_q[2*N-1:N]),
    .quot_i    (acc_q[N-2:0]),
    .dvd_bit_i (dvd_q[N-1]),
    .dvsr_i    (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dvd_q   <= '0;
      dvsr_q  <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.divOrMult) begin
          state_d = b_zero ? DONE : ITER;
        end
      end
      ITER: begin
        if (last_step) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.divOrMult) begin
          if (b_zero) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = abs_val(bus.outA);
            dvsr_d  = abs_val(bus.outB);
            sgn_a_d = bus.outA[N-1];
            sgn_b_d = bus.outB[N-1];
            acc_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
          end
        end
      end
      ITER: begin
        acc_d = {step_rem, step_quot};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        lo_d   = cond_neg(acc_q[N-1:0], sgn_a_q ^ sgn_b_q);
        hi_d   = cond_neg(acc_q[2*N-1:N], sgn_a_q);
        done_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign bus.lo      = lo_q;
  assign bus.hi      = hi_q;
  assign bus.divZero = dz_q;
  assign bus.divDone = done_q;

endmodule

// File: tb/tb_divisor.sv
// Bench for divisor: directed vector table, multi-cycle corner sequences and
// random signed pairs, with results matched against a scoreboard queue.
module tb_divisor;
  import divisor_pkg::*;

  logic clock = 1'b0;
  logic reset;

  divisor_if dif ();

  divisor #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  int          dones  = 0;
  int          pushes = 0;
  logic [31:0] model_lo = '0;
  logic [31:0] model_hi = '0;
  vec_t        tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] plo, input logic [31:0] phi);
    exp_t   e;
    longint q;
    longint r;
    if (b == 32'd0) begin
      e.lo = plo;
      e.hi = phi;
      e.dz = 1'b1;
    end else begin
      q    = longint'($signed(a)) / longint'($signed(b));
      r    = longint'($signed(a)) % longint'($signed(b));
      e.lo = q[31:0];
      e.hi = r[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Result checker: every divDone pulse must match the oldest pending request.
  always @(negedge clock) begin
    if (dif.divDone === 1'b1) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_done: got divDone=1, expected no pending request");
      end else begin
        mon_e = sb.pop_front();
        check("lo", dif.lo, mon_e.lo);
        check("hi", dif.hi, mon_e.hi);
        check("divZero", {31'b0, dif.divZero}, {31'b0, mon_e.dz});
      end
    end
  end

  // Issue one request, measure edges from E0 to divDone, confirm one-cycle pulse.
  // disturb_at > 0 re-asserts divOrMult with garbage operands mid-operation.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int disturb_at);
    int lat;
    bit seen;
    sb.push_back(e);
    pushes++;
    if (!e.dz) begin
      model_lo = e.lo;
      model_hi = e.hi;
    end
    @(negedge clock);
    dif.outA      = a;
    dif.outB      = b;
    dif.divOrMult = 1'b1;
    @(posedge clock);
    #1;
    dif.divOrMult = 1'b0;
    lat  = 0;
    seen = dif.divDone;
    while (!seen && lat < 40) begin
      @(posedge clock);
      lat++;
      #1;
      if (disturb_at != 0 && lat == disturb_at) begin
        dif.divOrMult = 1'b1;
        dif.outA      = $urandom;
        dif.outB      = $urandom;
      end
      if (disturb_at != 0 && lat == disturb_at + 3) dif.divOrMult = 1'b0;
      seen = dif.divDone;
    end
    check($sformatf("latency a=%08h b=%08h", a, b), lat, e.dz ? 32'd0 : 32'd33);
    @(posedge clock);
    #1;
    check("done_pulse_end", {31'b0, dif.divDone}, 32'd0);
    $display("div a=0x%08h b=0x%08h -> lo=0x%08h hi=0x%08h dz=%0b lat=%0d",
             a, b, dif.lo, dif.hi, dif.divZero, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0] = '{32'd7,         32'd2,         32'd3,         32'd1,         1'b0};
    tbl[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    tbl[2] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    tbl[3] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
    tbl[4] = '{32'h12345678,  32'd0,         32'd3,         32'hFFFFFFFF,  1'b1};
    tbl[5] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    tbl[6] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
    tbl[7] = '{32'hFFFFFFFF,  32'h80000000,  32'd0,         32'hFFFFFFFF,  1'b0};
    tbl[8] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0};

    dif.outA      = '0;
    dif.outB      = '0;
    dif.divOrMult = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_lo", dif.lo, 32'd0);
    check("reset_hi", dif.hi, 32'd0);
    check("reset_divZero", {31'b0, dif.divZero}, 32'd0);
    check("reset_divDone", {31'b0, dif.divDone}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      e.lo = tbl[i].lo;
      e.hi = tbl[i].hi;
      e.dz = tbl[i].dz;
      run_div(tbl[i].a, tbl[i].b, e, 0);
    end

    // divOrMult pulse and operand changes around E5 must not disturb the operation.
    e = ref_div(32'd1000, 32'hFFFFFFDF, model_lo, model_hi);
    run_div(32'd1000, 32'hFFFFFFDF, e, 4);
    // Divide-by-zero issued right after the previous DONE.
    e = ref_div(32'hDEADBEEF, 32'd0, model_lo, model_hi);
    run_div(32'hDEADBEEF, 32'd0, e, 0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 20)) : 32'($urandom_range(1, 20));
      if (i % 7 == 6) b = 32'd0;
      e = ref_div(a, b, model_lo, model_hi);
      run_div(a, b, e, 0);
    end

    e = ref_div(32'hFFFFFFF9, 32'd2, model_lo, model_hi);
    run_div(32'hFFFFFFF9, 32'd2, e, 0);

    // Abort mid-ITER: asynchronous clear, and the aborted request never completes.
    @(negedge clock);
    dif.outA      = 32'h7FFF0000;
    dif.outB      = 32'd3;
    dif.divOrMult = 1'b1;
    @(posedge clock);
    #1;
    dif.divOrMult = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_lo", dif.lo, 32'd0);
    check("abort_hi", dif.hi, 32'd0);
    check("abort_divZero", {31'b0, dif.divZero}, 32'd0);
    check("abort_divDone", {31'b0, dif.divDone}, 32'd0);
    $display("reset asserted mid-ITER: lo=0x%08h hi=0x%08h", dif.lo, dif.hi);
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    model_lo = '0;
    model_hi = '0;
    repeat (30) @(negedge clock);

    e.lo = 32'd14;
    e.hi = 32'd2;
    e.dz = 1'b0;
    run_div(32'd100, 32'd7, e, 0);

    repeat (3) @(negedge clock);
    check("pending_empty", sb.size(), 32'd0);
    check("done_count", dones, pushes);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/divisor.md
DIVISOR -- requirements
Module: divisor

Interface
REQ-001 Parameter: N, default 32, operand/result width; only N=32 is supported.
REQ-002 clock  input  1  sole clock, rising-edge active.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 outA  input  32  signed dividend, two's complement.
REQ-005 outB  input  32  signed divisor, two's complement.
REQ-006 divOrMult  input  1  1 = divide request, sampled only in IDLE; 0 = no request.
REQ-007 lo  output  32  signed quotient, registered.
REQ-008 hi  output  32  signed remainder, registered.
REQ-009 divZero  output  1  divide-by-zero flag, registered.
REQ-010 divDone  output  1  one-cycle completion pulse, registered.

Function
REQ-011 FSM states SHALL be IDLE, ITER, FIX and DONE; reset state SHALL be IDLE.
REQ-012 IDLE with divOrMult=1 at edge E0, outB!=0: latch |outA|, |outB|, both sign bits; clear the 64-bit remainder/quotient register; clear the 6-bit step counter; clear divZero; go to ITER.
REQ-013 IDLE with divOrMult=1 at E0, outB==0: set divZero=1 and divDone=1; hold lo/hi; go to DONE.
REQ-014 ITER SHALL run one restoring step per edge (E1..E32): shift {rem,quot} left 1 bit; trial subtract divisor from rem (33-bit); if result is non-negative, keep it and set quotient LSB=1, else restore and set quotient LSB=0.
REQ-015 On the edge where the counter reaches 32 (E32), the FSM SHALL go to FIX.
REQ-016 FIX (edge E33): lo = quotient, negated if dividend sign != divisor sign; hi = remainder, negated if dividend sign = 1; divDone=1; go to DONE.
REQ-017 DONE (next edge): divDone=0; go to IDLE. divDone SHALL be high for exactly one cycle per request.
REQ-018 Latency: divDone high between E33 and E34 for a normal divide; between E0 and E1 for divide-by-zero.
REQ-019 Quotient SHALL truncate toward zero; remainder SHALL carry the dividend's sign; |hi| < |outB|.
REQ-020 Overflow case 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag.
REQ-021 Absolute values SHALL be formed as 32-bit unsigned; |0x80000000| = 0x80000000.
REQ-022 divOrMult SHALL be ignored in ITER, FIX and DONE; outA/outB changes after E0 SHALL not affect the result.
REQ-023 lo/hi SHALL hold their last value until the next FIX; divZero SHALL hold until the next accepted request.
REQ-024 Back-to-back: a request seen in IDLE on the edge right after DONE SHALL be accepted.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE and clear lo, hi, divZero, divDone, the counter and the internal registers, without waiting for a clock edge.
REQ-026 Reset during ITER or FIX SHALL abort the operation; no divDone pulse SHALL follow.
REQ-027 After reset deasserts, the first accepted request SHALL behave per REQ-012/013.

Structure
REQ-028 State encodings (2-bit) and the width constant N SHALL live in the shared definitions include used by the arithmetic blocks.
REQ-029 One combinational sub-module, div_step, SHALL implement a single shift/trial-subtract/restore step; divisor SHALL instantiate it once.
REQ-030 No other sub-modules; the counter and FSM SHALL live in divisor.

Verification
REQ-031 7 / 2 -> lo=0x00000003, hi=0x00000001, divDone pulse at E33, divZero=0.
REQ-032 -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001; -7 / -2 -> lo=0x00000003, hi=0xFFFFFFFF.
REQ-033 0x12345678 / 0 after a prior result -> divZero=1, divDone pulse at E0, lo/hi unchanged.
REQ-034 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then 0 / 5 -> lo=0, hi=0.
REQ-035 Assert reset mid-ITER (E10) -> all outputs 0 immediately, no divDone; then 100 / 7 -> lo=14, hi=2.
REQ-036 Pulse divOrMult=1 at E5 during a divide and change outA/outB -> ignored; original result returned with a single divDone; random signed pairs are checked against a reference model.
